// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage ahead of the SISC control FSM.
//
// Holds the program counter and instruction register. Computes PC updates
// from the ctrl strobes. Loads the IR through a req/ack handshake with
// instruction memory, which may insert any number of wait states. Decodes
// the IR fields for ctrl, the register file and the ALU.
//
// Ports:
//   clk, rst_f            clock (posedge), asynchronous active-low reset
//   pc_rst                synchronous PC clear (wins over pc_write)
//   pc_write, pc_sel      PC update strobe; select 0 = PC+1, 1 = branch
//   br_sel                branch mode: 1 = absolute imm, 0 = PC+imm
//   ir_load               start a fetch at the current PC
//   im_addr, im_req       memory address/request, held stable until ack
//   im_rdata, im_ack      memory read data and its one-cycle valid pulse
//   busy                  a fetch is outstanding
//   ir_valid              one-cycle pulse, IR updated this cycle
//   pc_out                current PC
//   opcode/mm/rd/rs/rt/imm  combinational IR field decodes
//   fetch_err             sticky protocol/timeout error, cleared only by rst_f
//
// Build option:
//   FETCH_TIMEOUT_EN  when defined, a fetch with no ack for TIMEOUT WAIT cycles
//                     completes with a NOOP IR and raises fetch_err.
module fetch_unit #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst_f,
   input  logic               pc_rst,
   input  logic               pc_write,
   input  logic               pc_sel,
   input  logic               br_sel,
   input  logic               ir_load,
   output logic [ADDR_W-1:0]  im_addr,
   output logic               im_req,
   input  logic [INSTR_W-1:0] im_rdata,
   input  logic               im_ack,
   output logic               busy,
   output logic               ir_valid,
   output logic [ADDR_W-1:0]  pc_out,
   output logic [3:0]         opcode,
   output logic [3:0]         mm,
   output logic [3:0]         rd,
   output logic [3:0]         rs,
   output logic [3:0]         rt,
   output logic [15:0]        imm,
   output logic               fetch_err
);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   localparam logic [ADDR_W-1:0] PcInc = ADDR_W'(1);

   state_e               state_q;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0]   ir_q;
   logic [ADDR_W-1:0]    im_addr_q;
   logic                 im_req_q;
   logic                 ir_valid_q;
   logic                 fetch_err_q;
   logic [ADDR_W-1:0]    imm_ext;

   // Immediate is unsigned; sizing it to the PC width makes PC+imm wrap.
   assign imm_ext = ADDR_W'(ir_q[15:0]);

   // ---------------------------------------------------------------------
   // Program counter
   // ---------------------------------------------------------------------
   always_comb begin
      pc_d = pc_q;
      if (pc_rst) begin
         pc_d = '0;
      end else if (pc_write) begin
         if (!pc_sel) begin
            pc_d = pc_q + PcInc;
         end else if (br_sel) begin
            pc_d = imm_ext;
         end else begin
            pc_d = pc_q + imm_ext;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   // ---------------------------------------------------------------------
   // Fetch FSM with registered outputs
   // ---------------------------------------------------------------------
`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned      CntW    = $clog2(TIMEOUT + 1);
   // Count holds the WAIT cycles already spent; the edge that would make it
   // reach TIMEOUT is the timeout edge.
   localparam logic [CntW-1:0]  CntLast = CntW'(TIMEOUT - 1);
   localparam logic [CntW-1:0]  CntOne  = CntW'(1);
   logic [CntW-1:0]             cnt_q;
`endif

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state_q     <= StIdle;
         ir_q        <= '0;
         im_addr_q   <= '0;
         im_req_q    <= 1'b0;
         ir_valid_q  <= 1'b0;
         fetch_err_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         ir_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // An ack with nothing outstanding is a protocol error.
               if (im_ack) begin
                  fetch_err_q <= 1'b1;
               end
               if (ir_load) begin
                  // pc_q is the pre-update PC even if pc_write is also high.
                  im_addr_q <= pc_q;
                  im_req_q  <= 1'b1;
                  state_q   <= StWait;
`ifdef FETCH_TIMEOUT_EN
                  cnt_q     <= '0;
`endif
               end
            end
            StWait: begin
               // A second load while one is outstanding is dropped.
               if (ir_load) begin
                  fetch_err_q <= 1'b1;
               end
               if (im_ack) begin
                  ir_q       <= im_rdata;
                  im_req_q   <= 1'b0;
                  ir_valid_q <= 1'b1;
                  state_q    <= StIdle;
               end
`ifdef FETCH_TIMEOUT_EN
               else if (cnt_q == CntLast) begin
                  ir_q        <= '0;
                  im_req_q    <= 1'b0;
                  ir_valid_q  <= 1'b1;
                  fetch_err_q <= 1'b1;
                  state_q     <= StIdle;
               end else begin
                  cnt_q <= cnt_q + CntOne;
               end
`endif
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign im_addr   = im_addr_q;
   assign im_req    = im_req_q;
   assign busy      = (state_q == StWait);
   assign ir_valid  = ir_valid_q;
   assign fetch_err = fetch_err_q;
   assign pc_out    = pc_q;

   assign opcode = ir_q[31:28];
   assign mm     = ir_q[27:24];
   assign rd     = ir_q[23:20];
   assign rs     = ir_q[19:16];
   assign rt     = ir_q[15:12];
   assign imm    = ir_q[15:0];

endmodule
